// File: rtl/puf_host_link_if.sv
// Host-side handshake bundle for the PUF challenge/response link.
// The master issues challenges; the slave (puf_host_link) reports the response.
interface puf_host_link_if;
   logic         start;
   logic [15:0]  challenge;
   logic         busy;
   logic [127:0] response;
   logic         resp_valid;
   logic         err;
   logic [1:0]   err_code;

   modport master (
      output start, challenge,
      input  busy, response, resp_valid, err, err_code
   );

   modport slave (
      input  start, challenge,
      output busy, response, resp_valid, err, err_code
   );
endinterface

// File: rtl/puf_host_link.sv
// Host end of the PUF UART link: sends a 16-bit challenge (8N1, LSB first)
// and collects the 16-byte response, with timeout and framing-error detection.
module puf_host_link #(
   parameter int CLKS_PER_BIT = 868,
   parameter int TIMEOUT_CLKS = 2_000_000
) (
   input  logic            clk,
   input  logic            rst_n,
   puf_host_link_if.slave  host,
   output logic            tx_out,
   input  logic            rx
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CLKS);

   typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RXB, S_DONE, S_ERR} state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] clk_cnt_reg;
   logic [4:0]       bit_cnt_reg;
   logic [TO_W-1:0]  to_cnt_reg;
   logic [3:0]       byte_cnt_reg;
   logic [18:0]      tx_frame_reg;
   logic [7:0]       rx_byte_reg;
   logic [119:0]     resp_buf_reg;
   logic [127:0]     response_reg;
   logic             resp_valid_reg;
   logic             err_reg;
   logic [1:0]       err_code_reg;
   logic             busy_reg;
   logic             tx_out_reg;
   logic             rx_meta_reg;
   logic             rx_sync_reg;
   logic             rx_prev_reg;

   logic             rx_fall;
   logic [TO_W-1:0]  to_cnt_next;

   assign rx_fall     = rx_prev_reg & ~rx_sync_reg;
   assign to_cnt_next = (to_cnt_reg == TO_MAX) ? TO_MAX : to_cnt_reg + TO_W'(1);

   assign tx_out          = tx_out_reg;
   assign host.busy       = busy_reg;
   assign host.response   = response_reg;
   assign host.resp_valid = resp_valid_reg;
   assign host.err        = err_reg;
   assign host.err_code   = err_code_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         clk_cnt_reg    <= '0;
         bit_cnt_reg    <= '0;
         to_cnt_reg     <= '0;
         byte_cnt_reg   <= '0;
         tx_frame_reg   <= '1;
         rx_byte_reg    <= '0;
         resp_buf_reg   <= '0;
         response_reg   <= '0;
         resp_valid_reg <= 1'b0;
         err_reg        <= 1'b0;
         err_code_reg   <= 2'b00;
         busy_reg       <= 1'b0;
         tx_out_reg     <= 1'b1;
         rx_meta_reg    <= 1'b1;
         rx_sync_reg    <= 1'b1;
         rx_prev_reg    <= 1'b1;
      end else begin
         rx_meta_reg    <= rx;
         rx_sync_reg    <= rx_meta_reg;
         rx_prev_reg    <= rx_sync_reg;
         resp_valid_reg <= 1'b0;
         err_reg        <= 1'b0;

         case (state_reg)
            // DONE/ERR are the pulse cycles; a new start is already accepted there
            S_IDLE, S_DONE, S_ERR: begin
               state_reg <= S_IDLE;
               if (host.start) begin
                  tx_frame_reg <= {1'b1, host.challenge[15:8], 1'b0, 1'b1, host.challenge[7:0]};
                  tx_out_reg   <= 1'b0;
                  busy_reg     <= 1'b1;
                  clk_cnt_reg  <= '0;
                  bit_cnt_reg  <= '0;
                  byte_cnt_reg <= '0;
                  state_reg    <= S_TX;
               end
            end

            S_TX: begin
               if (clk_cnt_reg == BIT_LAST) begin
                  clk_cnt_reg <= '0;
                  if (bit_cnt_reg == 5'd19) begin
                     to_cnt_reg <= '0;
                     state_reg  <= S_WAIT;
                  end else begin
                     bit_cnt_reg  <= bit_cnt_reg + 5'd1;
                     tx_out_reg   <= tx_frame_reg[0];
                     tx_frame_reg <= {1'b1, tx_frame_reg[18:1]};
                  end
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
               end
            end

            S_WAIT: begin
               to_cnt_reg <= to_cnt_next;
               if (rx_fall) begin
                  clk_cnt_reg <= '0;
                  bit_cnt_reg <= '0;
                  state_reg   <= S_RXB;
               end else if (to_cnt_next == TO_MAX) begin
                  err_reg      <= 1'b1;
                  err_code_reg <= 2'b01;
                  busy_reg     <= 1'b0;
                  state_reg    <= S_ERR;
               end
            end

            S_RXB: begin
               to_cnt_reg <= to_cnt_next;
               if (bit_cnt_reg == 5'd0) begin
                  // Mid-start-bit recheck: a high line here means the edge was a glitch
                  if (clk_cnt_reg == HALF_LAST) begin
                     clk_cnt_reg <= '0;
                     if (rx_sync_reg)
                        state_reg <= S_WAIT;
                     else
                        bit_cnt_reg <= 5'd1;
                  end else begin
                     clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                  end
               end else if (clk_cnt_reg == BIT_LAST) begin
                  clk_cnt_reg <= '0;
                  if (bit_cnt_reg < 5'd9) begin
                     rx_byte_reg <= {rx_sync_reg, rx_byte_reg[7:1]};
                     bit_cnt_reg <= bit_cnt_reg + 5'd1;
                  end else if (!rx_sync_reg) begin
                     err_reg      <= 1'b1;
                     err_code_reg <= 2'b10;
                     busy_reg     <= 1'b0;
                     state_reg    <= S_ERR;
                  end else if (byte_cnt_reg == 4'd15) begin
                     response_reg   <= {rx_byte_reg, resp_buf_reg};
                     resp_valid_reg <= 1'b1;
                     busy_reg       <= 1'b0;
                     state_reg      <= S_DONE;
                  end else begin
                     resp_buf_reg <= {rx_byte_reg, resp_buf_reg[119:8]};
                     byte_cnt_reg <= byte_cnt_reg + 4'd1;
                     to_cnt_reg   <= '0;
                     state_reg    <= S_WAIT;
                  end
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
               end
            end

            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_host_link.sv
// Directed bench for puf_host_link: challenge framing, response capture,
// timeout, framing error, rx glitch, held start and asynchronous reset.
module tb_puf_host_link;
   localparam int CPB = 4;
   localparam int TO  = 100;

   localparam logic [127:0] R1 = 128'hABCDEF9876543210ABCDEF9876543210;
   localparam logic [127:0] R2 = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] R3 = 128'h00112233445566778899AABBCCDDEEFF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   logic tx_out;

   int errors = 0;
   int checks = 0;

   int   rv_count = 0;
   int   err_count = 0;
   logic [1:0] code_at_err = 2'b00;
   logic busy_at_pulse = 1'b1;
   logic busy_before_pulse = 1'b0;
   logic busy_prev = 1'b0;

   puf_host_link_if host ();

   puf_host_link #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .host   (host),
      .tx_out (tx_out),
      .rx     (rx)
   );

   always #5 clk = ~clk;

   // Pulse monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (host.resp_valid || host.err) begin
         busy_at_pulse     <= host.busy;
         busy_before_pulse <= busy_prev;
      end
      if (host.resp_valid) rv_count <= rv_count + 1;
      if (host.err) begin
         err_count   <= err_count + 1;
         code_at_err <= host.err_code;
      end
      busy_prev <= host.busy;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop;
      tick(CPB);
      rx = 1'b1;
   endtask

   task automatic send_resp(input logic [127:0] r);
      for (int k = 0; k < 16; k++) send_frame(r[8*k +: 8], 1'b1);
   endtask

   task automatic start_txn(input logic [15:0] ch);
      host.challenge = ch;
      host.start = 1'b1;
      tick(1);
      host.start = 1'b0;
      $display("txn: challenge=%h accepted busy=%b tx_out=%b", ch, host.busy, tx_out);
   endtask

   logic [0:19] tx_exp;
   logic        tx_low;

   initial begin
      host.start = 1'b0;
      host.challenge = 16'h0000;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      check("reset_tx_out", tx_out, 1);
      check("reset_busy", host.busy, 0);
      check("reset_response", host.response, 0);
      check("reset_resp_valid", host.resp_valid, 0);
      check("reset_err", host.err, 0);
      check("reset_err_code", host.err_code, 0);

      // Challenge A5C3 framing, each bit exactly CPB cycles
      tx_exp = 20'b0_11000011_1_0_10100101_1;
      start_txn(16'hA5C3);
      check("tx_busy_after_start", host.busy, 1);
      for (int i = 0; i < 20; i++) begin
         check($sformatf("tx_bit%0d_first", i), tx_out, tx_exp[i]);
         tick(CPB - 1);
         check($sformatf("tx_bit%0d_last", i), tx_out, tx_exp[i]);
         tick(1);
      end
      check("tx_idle_in_wait", tx_out, 1);
      check("busy_in_wait", host.busy, 1);

      // Full reply R1
      send_resp(R1);
      tick(5);
      $display("txn: reply R1 resp_valid_count=%0d response=%h", rv_count, host.response);
      check("r1_valid_count", rv_count, 1);
      check("r1_response", host.response, R1);
      check("r1_err_count", err_count, 0);
      check("r1_busy_at_pulse", busy_at_pulse, 0);
      check("r1_busy_before_pulse", busy_before_pulse, 1);
      check("r1_valid_low_after", host.resp_valid, 0);

      // Timeout: err exactly TO cycles after WAIT entry
      start_txn(16'h1234);
      tick(80);
      tick(TO - 1);
      check("to_err_early", host.err, 0);
      check("to_busy_early", host.busy, 1);
      tick(1);
      $display("txn: timeout err=%b err_code=%b", host.err, host.err_code);
      check("to_err", host.err, 1);
      check("to_err_code", host.err_code, 2'b01);
      check("to_busy_fall", host.busy, 0);
      check("to_response_kept", host.response, R1);
      // start in the first cycle after busy falls
      start_txn(16'h5A5A);
      check("to_err_one_cycle", host.err, 0);
      check("restart_busy", host.busy, 1);
      check("restart_tx_start", tx_out, 0);

      // Framing error on byte 5
      tick(80);
      for (int k = 0; k < 5; k++) send_frame(R2[8*k +: 8], 1'b1);
      send_frame(R2[47:40], 1'b0);
      tick(5);
      $display("txn: framing err_count=%0d code=%b", err_count, code_at_err);
      check("fr_err_count", err_count, 2);
      check("fr_err_code", code_at_err, 2'b10);
      check("fr_no_valid", rv_count, 1);
      check("fr_response_kept", host.response, R1);
      check("fr_busy", host.busy, 0);
      check("fr_code_held", host.err_code, 2'b10);

      // Held start, rx glitch in WAIT, then full reply R2
      host.challenge = 16'hA5C3;
      host.start = 1'b1;
      tick(1);
      check("hold_busy", host.busy, 1);
      tick(80);
      tx_low = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!tx_out) tx_low = 1'b1;
         tick(1);
      end
      host.start = 1'b0;
      check("hold_single_challenge", tx_low, 0);
      check("hold_busy_wait", host.busy, 1);
      rx = 1'b0;
      tick(1);
      rx = 1'b1;
      tick(10);
      check("glitch_still_busy", host.busy, 1);
      send_resp(R2);
      tick(5);
      $display("txn: glitch+reply R2 resp_valid_count=%0d response=%h", rv_count, host.response);
      check("r2_valid_count", rv_count, 2);
      check("r2_response", host.response, R2);
      check("r2_err_count", err_count, 2);

      // Asynchronous reset during TX start bit
      start_txn(16'h0F0F);
      check("rst_tx_pre", tx_out, 0);
      #3 rst_n = 1'b0;
      #1;
      check("rst_tx_tx_out", tx_out, 1);
      check("rst_tx_busy", host.busy, 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // Asynchronous reset in the middle of a response
      start_txn(16'h0F0F);
      tick(80);
      for (int k = 0; k < 7; k++) send_frame(R3[8*k +: 8], 1'b1);
      rx = 1'b0;
      tick(6);
      #2 rst_n = 1'b0;
      #1;
      $display("txn: reset mid-response busy=%b tx_out=%b", host.busy, tx_out);
      check("rst_rx_busy", host.busy, 0);
      check("rst_rx_tx_out", tx_out, 1);
      check("rst_rx_response", host.response, 0);
      check("rst_rx_err_code", host.err_code, 0);
      rx = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(3);

      // Normal transaction after reset
      start_txn(16'h3C3C);
      tick(80);
      send_resp(R3);
      tick(5);
      $display("txn: reply R3 resp_valid_count=%0d response=%h", rv_count, host.response);
      check("r3_valid_count", rv_count, 3);
      check("r3_response", host.response, R3);
      check("r3_err_count", err_count, 2);
      check("r3_busy", host.busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/puf_host_link.md
# puf_host_link

Host-side end of the PUF challenge/response UART link. It serialises a 16-bit challenge onto a UART line toward the PUF board, then deserialises the 128-bit response that the board sends back. It reports the result with a one-cycle valid pulse, or with an error pulse on timeout or framing fault. It sits in the test/host FPGA and pairs with the board's 16-bit receiver and 128-bit transmitter.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (sim uses 4); minimum 4.
- TIMEOUT_CLKS, 2_000_000, maximum idle cycles while waiting for any response start bit.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset; one clock domain.
- start  input  1  request a transaction; sampled only when busy=0.
- challenge  input  16  challenge word, latched on accepted start.
- tx_out  output  1  UART line to PUF board, idle high.
- rx  input  1  UART line from PUF board; asynchronous, 2-flop synchronised inside.
- busy  output  1  high from the cycle after an accepted start until completion or error.
- response  output  128  last good response; updated only together with resp_valid.
- resp_valid  output  1  one-cycle pulse when a complete response has been received.
- err  output  1  one-cycle pulse on timeout or framing error.
- err_code  output  2  valid with err: 01 = timeout, 10 = framing; holds its value until the next err.

## Operation
- Frame format: 8N1, LSB first. One start bit (0), 8 data bits, one stop bit (1).
- Challenge is sent as 2 bytes, low byte first: challenge[7:0], then challenge[15:8].
- Response is received as 16 bytes. Byte k (k=0..15) is stored to response[8k+7:8k].
- States:
  - IDLE: start=1 → latch challenge, go to TX.
  - TX: send both bytes back-to-back, no inter-byte gap; after the 2nd stop bit completes → WAIT.
  - WAIT: falling edge on synchronised rx → RXB; timeout counter reaches TIMEOUT_CLKS → ERR(timeout).
  - RXB: receive one byte. Stop bit good and byte count <16 → WAIT (timeout counter cleared). Stop bit good and 16th byte → DONE. Stop bit low → ERR(framing).
  - DONE: pulse resp_valid, copy the shift buffer to response → IDLE.
  - ERR: pulse err, set err_code → IDLE.
- RX sampling:
  - Start bit is re-checked at mid-bit (CLKS_PER_BIT/2 cycles after the edge). If rx is high there, treat it as a glitch: return to WAIT without counting the byte; the timeout counter keeps running.
  - Data bits and the stop bit are sampled every CLKS_PER_BIT cycles after that mid-bit point.
- Response assembly: a separate 128-bit shift buffer collects the bytes. The response output is never partially updated.
- rx activity in IDLE or TX is ignored; the falling-edge detector is only armed in WAIT.
- start while busy=1 is ignored, with no queuing.

## Timing
- Reset values: tx_out=1, busy=0, response=0, resp_valid=0, err=0, err_code=0, state IDLE, all counters 0.
- start accepted at edge N → busy=1 and tx_out=0 (start bit) from edge N+1.
- Each TX bit is held exactly CLKS_PER_BIT cycles. Challenge TX lasts 20·CLKS_PER_BIT cycles.
- rx path latency: 2 cycles of synchroniser, plus 1 cycle for edge detect.
- resp_valid and err are high exactly one cycle. busy falls on the same edge that raises either pulse.
- start may be asserted in the first cycle after busy falls and is accepted then.
- Timeout counter saturates at TIMEOUT_CLKS and never wraps. It is cleared on entering WAIT.
- Reset asserted mid-transaction: all outputs return to their reset values immediately and asynchronously; tx_out is driven high, aborting any partial frame.

## Test plan
- CLKS_PER_BIT=4, challenge=16'hA5C3 → tx_out carries 0,11000011,1,0,10100101,1 (bits in transmit order), each bit 4 cycles; busy high from the cycle after start.
- Board model replies 128'hABCDEF9876543210ABCDEF9876543210, sent as 16 bytes starting with 8'h10 → one resp_valid pulse, response equals that value, busy falls the same cycle, err stays 0.
- No reply, TIMEOUT_CLKS=100 → err pulse with err_code=01 at WAIT entry +100 cycles; response unchanged from its prior value.
- Byte 5 of the response has its stop bit forced to 0 → err with err_code=10, no resp_valid, response unchanged.
- A 1-cycle low glitch on rx in WAIT → no byte counted; the following full 16-byte reply is received correctly.
- start held high during a transaction → only one challenge is transmitted. rst_n pulsed low mid-response → tx_out=1, busy=0, and the next transaction completes normally.
